// File: rtl/biquad_mac_sequencer_if.sv
// Sample handshake, coefficient, MAC operand and filter output bundle for biquad_mac_sequencer.
// The slave modport is the sequencer view; the master modport is the upstream/MAC side.
interface biquad_mac_sequencer_if;
   logic signed [15:0] sample_in;
   logic               sample_valid;
   logic               sample_ready;
   logic               flush;
   logic signed [15:0] coef_b0;
   logic signed [15:0] coef_b1;
   logic signed [15:0] coef_b2;
   logic signed [15:0] coef_a1;
   logic signed [15:0] coef_a2;
   logic signed [15:0] mac_a;
   logic signed [15:0] mac_b;
   logic               mac_ce;
   logic               mac_clr;
   logic signed [31:0] mac_result;
   logic signed [15:0] y_out;
   logic               y_valid;

   modport slave (
      input  sample_in, sample_valid, flush,
      input  coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
      input  mac_result,
      output sample_ready, mac_a, mac_b, mac_ce, mac_clr, y_out, y_valid
   );

   modport master (
      output sample_in, sample_valid, flush,
      output coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
      output mac_result,
      input  sample_ready, mac_a, mac_b, mac_ce, mac_clr, y_out, y_valid
   );
endinterface

// File: rtl/biquad_mac_sequencer.sv
// Direct-Form-I biquad sequencer: drives five MAC products per sample, requantises Q4.28 to Q2.14.
// Define BIQUAD_ROUND_EN for round-half-up requantisation; otherwise the accumulator is truncated.
module biquad_mac_sequencer #(
   parameter int MAC_LAT = 2
) (
   input logic                  clk,
   input logic                  rst,
   biquad_mac_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CLEAR     = 3'd1,
      ISSUE     = 3'd2,
      DRAIN     = 3'd3,
      WRITEBACK = 3'd4
   } state_t;

   state_t             state;
   logic [2:0]         tap;
   logic [7:0]         drain_cnt;
   logic signed [15:0] x_r, b0_r, b1_r, b2_r, a1_r, a2_r;
   logic signed [15:0] x1, x2, y1, y2;
   logic signed [15:0] mac_a_r, mac_b_r, y_out_r;
   logic               mac_ce_r, mac_clr_r, y_valid_r;
   logic [2:0]         sel;
   logic signed [15:0] op_a, op_b;
   logic signed [15:0] q;

   function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
      return (v == 16'sh8000) ? 16'sh7FFF : -v;
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
      if (v > 33'sd32767)
         return 16'sh7FFF;
      else if (v < -33'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   // Widened to 33 bits so the rounding offset can never wrap the accumulator.
   function automatic logic signed [15:0] requant(input logic signed [31:0] acc);
      logic signed [32:0] ext;
      logic signed [32:0] shifted;
`ifdef BIQUAD_ROUND_EN
      ext = {acc[31], acc} + 33'sd8192;
`else
      ext = {acc[31], acc};
`endif
      shifted = ext >>> 14;
      return sat16(shifted);
   endfunction

   assign q = requant(bus.mac_result);

   // Operands are registered one cycle ahead, so select the pair for the tap about to issue.
   always_comb begin
      sel  = (state == ISSUE) ? (tap + 3'd1) : 3'd0;
      op_a = '0;
      op_b = '0;
      case (sel)
         3'd0: begin op_a = b0_r; op_b = x_r;          end
         3'd1: begin op_a = b1_r; op_b = x1;           end
         3'd2: begin op_a = b2_r; op_b = x2;           end
         3'd3: begin op_a = a1_r; op_b = neg_sat(y1);  end
         3'd4: begin op_a = a2_r; op_b = neg_sat(y2);  end
         default: begin op_a = '0; op_b = '0;          end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         tap       <= '0;
         drain_cnt <= '0;
         x_r       <= '0;
         b0_r      <= '0;
         b1_r      <= '0;
         b2_r      <= '0;
         a1_r      <= '0;
         a2_r      <= '0;
         x1        <= '0;
         x2        <= '0;
         y1        <= '0;
         y2        <= '0;
         mac_a_r   <= '0;
         mac_b_r   <= '0;
         mac_ce_r  <= 1'b0;
         mac_clr_r <= 1'b0;
         y_out_r   <= '0;
         y_valid_r <= 1'b0;
      end else begin
         y_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.flush) begin
                  x1 <= '0;
                  x2 <= '0;
                  y1 <= '0;
                  y2 <= '0;
               end else if (bus.sample_valid) begin
                  x_r       <= bus.sample_in;
                  b0_r      <= bus.coef_b0;
                  b1_r      <= bus.coef_b1;
                  b2_r      <= bus.coef_b2;
                  a1_r      <= bus.coef_a1;
                  a2_r      <= bus.coef_a2;
                  mac_clr_r <= 1'b1;
                  state     <= CLEAR;
               end
            end
            CLEAR: begin
               mac_clr_r <= 1'b0;
               mac_ce_r  <= 1'b1;
               mac_a_r   <= op_a;
               mac_b_r   <= op_b;
               tap       <= '0;
               state     <= ISSUE;
            end
            ISSUE: begin
               if (tap == 3'd4) begin
                  mac_a_r   <= '0;
                  mac_b_r   <= '0;
                  tap       <= '0;
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end else begin
                  tap     <= tap + 3'd1;
                  mac_a_r <= op_a;
                  mac_b_r <= op_b;
               end
            end
            // Zero operands keep the MAC clocked until the last product lands.
            DRAIN: begin
               if (drain_cnt == 8'(MAC_LAT - 1)) begin
                  mac_ce_r <= 1'b0;
                  state    <= WRITEBACK;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            WRITEBACK: begin
               y_out_r   <= q;
               y_valid_r <= 1'b1;
               x2        <= x1;
               x1        <= x_r;
               y2        <= y1;
               y1        <= q;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sample_ready = (state == IDLE);
   assign bus.mac_a        = mac_a_r;
   assign bus.mac_b        = mac_b_r;
   assign bus.mac_ce       = mac_ce_r;
   assign bus.mac_clr      = mac_clr_r;
   assign bus.y_out        = y_out_r;
   assign bus.y_valid      = y_valid_r;

endmodule

// File: tb/tb_biquad_mac_sequencer.sv
// Bench for biquad_mac_sequencer: a two-stage MAC model, a table of sample vectors with a
// scoreboard queue of expected outputs, and hand-written timing, reset and flush sequences.
module tb_biquad_mac_sequencer;

   typedef struct {
      bit          fl;
      logic [15:0] b0, b1, b2, a1, a2, x, y;
   } vec_t;

`ifdef BIQUAD_ROUND_EN
   localparam logic [15:0] RND_POS = 16'h0001;
   localparam logic [15:0] RND_NEG = 16'h0000;
`else
   localparam logic [15:0] RND_POS = 16'h0000;
   localparam logic [15:0] RND_NEG = 16'hFFFF;
`endif

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic [15:0] exp_q [$];
   vec_t tbl [$];

   biquad_mac_sequencer_if bus ();

   biquad_mac_sequencer #(.MAC_LAT(2)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // MAC model: product registered on mac_ce, accumulated the next cycle (two-cycle latency).
   logic signed [31:0] prod_p0, acc_p1;
   logic               vld_p0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_p0 <= '0;
         vld_p0  <= 1'b0;
         acc_p1  <= '0;
      end else begin
         vld_p0  <= bus.mac_ce;
         prod_p0 <= 32'(bus.mac_a) * 32'(bus.mac_b);
         if (bus.mac_clr)
            acc_p1 <= '0;
         else if (vld_p0)
            acc_p1 <= acc_p1 + prod_p0;
      end
   end
   assign bus.mac_result = acc_p1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every y_valid pulse pops and compares one expected output.
   always @(negedge clk) begin
      if (bus.y_valid) begin
         if (exp_q.size() == 0)
            check("unexpected_y_valid", 16'd1, 16'd0);
         else
            check("y_out", bus.y_out, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_ready();
      int guard = 0;
      @(negedge clk);
      while (!bus.sample_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("ready_timeout", 16'd0, 16'd1);
   endtask

   task automatic do_flush();
      wait_ready();
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
   endtask

   task automatic set_coefs(input vec_t v);
      bus.coef_b0   = v.b0;
      bus.coef_b1   = v.b1;
      bus.coef_b2   = v.b2;
      bus.coef_a1   = v.a1;
      bus.coef_a2   = v.a2;
      bus.sample_in = v.x;
   endtask

   // Accept one sample, then scramble inputs and pulse flush while busy; neither may matter.
   task automatic send(input vec_t v, input bit push);
      wait_ready();
      set_coefs(v);
      bus.sample_valid = 1'b1;
      if (push) exp_q.push_back(v.y);
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.sample_in    = 16'($urandom);
      bus.coef_b0      = 16'($urandom);
      bus.coef_b1      = 16'($urandom);
      bus.coef_b2      = 16'($urandom);
      bus.coef_a1      = 16'($urandom);
      bus.coef_a2      = 16'($urandom);
      bus.flush        = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_y_out"}, bus.y_out, 16'h0000);
      check({tag, "_y_valid"}, 16'(bus.y_valid), 16'd0);
      check({tag, "_mac_a"}, bus.mac_a, 16'h0000);
      check({tag, "_mac_b"}, bus.mac_b, 16'h0000);
      check({tag, "_mac_ce"}, 16'(bus.mac_ce), 16'd0);
      check({tag, "_mac_clr"}, 16'(bus.mac_clr), 16'd0);
      check({tag, "_ready"}, 16'(bus.sample_ready), 16'd1);
   endtask

   initial begin
      vec_t v;
      int   ce_cnt, clr_cnt, yv_cyc, yv_n;
      int   yv_at [3];

      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.sample_valid = 1'b0;
      bus.flush        = 1'b0;
      v = '{0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      set_coefs(v);

      tbl.push_back('{1, 16'h4000, 16'h0000, 16'h0000, 16'hE000, 16'h0000, 16'h4000, 16'h4000});
      tbl.push_back('{0, 16'h4000, 16'h0000, 16'h0000, 16'hE000, 16'h0000, 16'h0000, 16'h2000});
      tbl.push_back('{0, 16'h4000, 16'h0000, 16'h0000, 16'hE000, 16'h0000, 16'h0000, 16'h1000});
      tbl.push_back('{1, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF});
      tbl.push_back('{0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF});
      tbl.push_back('{1, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000});
      tbl.push_back('{0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000});
      tbl.push_back('{0, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h7FFF});
      tbl.push_back('{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF});
      tbl.push_back('{1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2000, RND_POS});
      tbl.push_back('{1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hE000, RND_NEG});
      tbl.push_back('{1, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h1000, 16'h0000});
      tbl.push_back('{0, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
      tbl.push_back('{0, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h1000});
      tbl.push_back('{1, 16'h2000, 16'h1000, 16'h0000, 16'hF000, 16'h0000, 16'h4000, 16'h2000});
      tbl.push_back('{0, 16'h2000, 16'h1000, 16'h0000, 16'hF000, 16'h0000, 16'h4000, 16'h3800});

      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Pass-through with cycle-accurate strobe accounting.
      do_flush();
      wait_ready();
      v = '{0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2000, 16'h2000};
      set_coefs(v);
      bus.sample_valid = 1'b1;
      exp_q.push_back(v.y);
      ce_cnt  = 0;
      clr_cnt = 0;
      yv_cyc  = -1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            bus.sample_valid = 1'b0;
            check("pt_clr_cycle1", 16'(bus.mac_clr), 16'd1);
         end
         if (cyc == 2) begin
            check("pt_tap0_mac_a", bus.mac_a, 16'h4000);
            check("pt_tap0_mac_b", bus.mac_b, 16'h2000);
         end
         if (bus.mac_ce) ce_cnt++;
         if (bus.mac_clr) clr_cnt++;
         if (bus.y_valid && yv_cyc < 0) yv_cyc = cyc;
      end
      check("pt_mac_ce_cycles", 16'(ce_cnt), 16'd7);
      check("pt_mac_clr_cycles", 16'(clr_cnt), 16'd1);
      check("pt_y_valid_cycle", 16'(yv_cyc), 16'd10);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].fl) do_flush();
         send(tbl[i], 1'b1);
      end

      // Reset during tap 2 after a completed sample left x1 = 0x7000.
      v = '{0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7000, 16'h7000};
      send(v, 1'b1);
      wait_ready();
      v = '{0, 16'h4000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0100, 16'h0000};
      set_coefs(v);
      bus.sample_valid = 1'b1;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tap2_mac_a", bus.mac_a, 16'h1234);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      v = '{0, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h1000};
      send(v, 1'b1);

      // flush wins over sample_valid; x1 = 0x1000 must be wiped.
      wait_ready();
      bus.flush        = 1'b1;
      bus.sample_valid = 1'b1;
      @(negedge clk);
      check("flush_no_accept", 16'(bus.sample_ready), 16'd1);
      bus.flush        = 1'b0;
      bus.sample_valid = 1'b0;
      v = '{0, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      send(v, 1'b1);

      // Back-to-back with sample_valid held high for three samples.
      do_flush();
      wait_ready();
      v = '{0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100};
      set_coefs(v);
      bus.sample_valid = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back(16'h0100);
      yv_n = 0;
      for (int k = 0; k < 3; k++) yv_at[k] = -1;
      for (int cyc = 1; cyc <= 34; cyc++) begin
         @(negedge clk);
         if (cyc == 21) bus.sample_valid = 1'b0;
         if (bus.y_valid) begin
            if (yv_n < 3) yv_at[yv_n] = cyc;
            yv_n++;
         end
      end
      check("b2b_pulse_count", 16'(yv_n), 16'd3);
      check("b2b_pulse0", 16'(yv_at[0]), 16'd10);
      check("b2b_pulse1", 16'(yv_at[1]), 16'd20);
      check("b2b_pulse2", 16'(yv_at[2]), 16'd30);

      begin
         int guard = 0;
         while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         if (exp_q.size() != 0) check("scoreboard_drain", 16'(exp_q.size()), 16'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
